// File: rtl/accum_n_stream.sv
// rtl/accum_n_stream.sv - streaming FP16 n-dimension reduction with rotating partial-sum slots
module fp16_add_pipe #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] z);
    logic [15:0] p, q;
    logic [5:0]  ep, eq, d, e, sh, lz_ext;
    logic [10:0] mp, mq;
    logic [27:0] wide;
    logic [14:0] ap, bq, sum, packed_v;
    logic [13:0] n;
    logic [4:0]  efield;
    logic [3:0]  lz;
    logic        found, rnd;
    if (x[14:0] >= z[14:0]) begin
      p = x; q = z;
    end else begin
      p = z; q = x;
    end
    if ((x[14:10] == 5'h1f && x[9:0] != 0) || (z[14:10] == 5'h1f && z[9:0] != 0))
      return 16'h7e00;
    if (p[14:10] == 5'h1f)
      return (q[14:10] == 5'h1f && p[15] != q[15]) ? 16'h7e00 : p;
    ep = (p[14:10] == 0) ? 6'd1 : {1'b0, p[14:10]};
    eq = (q[14:10] == 0) ? 6'd1 : {1'b0, q[14:10]};
    mp = {p[14:10] != 0, p[9:0]};
    mq = {q[14:10] != 0, q[9:0]};
    d = ep - eq;
    // three extra bits (guard, round, sticky) below the significand
    wide = {mq, 3'b000, 14'd0} >> ((d > 6'd27) ? 6'd27 : d);
    ap = {1'b0, mp, 3'b000};
    bq = {1'b0, wide[27:15], wide[14] | (|wide[13:0])};
    sum = (p[15] ^ q[15]) ? ap - bq : ap + bq;
    if (sum == 0)
      return (p[15] ^ q[15]) ? 16'h0000 : {p[15], 15'd0};
    if (sum[14]) begin
      n = {sum[14:2], sum[1] | sum[0]};
      e = ep + 6'd1;
    end else begin
      lz = 4'd0;
      found = 1'b0;
      for (int i = 13; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else lz = lz + 4'd1;
        end
      end
      lz_ext = {2'b00, lz};
      sh = (lz_ext > ep - 6'd1) ? ep - 6'd1 : lz_ext;
      n = sum[13:0] << sh;
      e = ep - sh;
    end
    if (n[13] && e >= 6'd31)
      return {p[15], 15'h7c00};
    efield = n[13] ? e[4:0] : 5'd0;
    rnd = n[2] & (n[1] | n[0] | n[3]);
    // a carry out of the fraction bumps the exponent, including subnormal to normal
    packed_v = {efield, n[12:3]} + {14'd0, rnd};
    if (packed_v[14:10] == 5'h1f)
      return {p[15], 15'h7c00};
    return {p[15], packed_v};
  endfunction

  logic [15:0] stage [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stage[i] <= 16'h0000;
    end else begin
      stage[0] <= fp16_add(a, b);
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign y = stage[LAT-1];

endmodule

module accum_n_stream #(
  parameter int DW      = 16,
  parameter int CH      = 4,
  parameter int N_MAX   = 128,
  parameter int ADD_LAT = 3,
  localparam int NW     = $clog2(N_MAX + 1),
  localparam int SLOTS  = ADD_LAT + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [NW-1:0]      n_len_i,
  output logic               busy_o,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [CH*DW-1:0]   s_data_i,
  input  logic               s_last_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [CH*DW-1:0]   m_sum_o,
  output logic               m_len_err_o
);

  localparam int IW = $clog2(SLOTS);
  localparam int FW = $clog2(SLOTS + 1);
  localparam int CW = $clog2(ADD_LAT + 1);

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, FOLD, OUT} state_t;

  state_t          state;
  logic [NW-1:0]   n_len, beat_cnt, n_clamp;
  logic [IW-1:0]   idx;
  logic [FW-1:0]   fold_i;
  logic [CW-1:0]   wait_cnt;
  logic [DW-1:0]   slot  [CH][SLOTS];
  logic [DW-1:0]   add_a [CH];
  logic [DW-1:0]   add_b [CH];
  logic [DW-1:0]   add_y [CH];
  logic            tag_v   [ADD_LAT];
  logic [IW-1:0]   tag_idx [ADD_LAT];
  logic            hs;

  assign hs      = s_valid_i & s_ready_o;
  assign n_clamp = (n_len_i > NW'(N_MAX)) ? NW'(N_MAX) : n_len_i;

  // During FOLD the adder output is chained back in, so the running total never lands in a slot
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      add_a[c] = slot[c][idx];
      add_b[c] = s_data_i[DW*c +: DW];
      if (state == FOLD) begin
        add_a[c] = (fold_i == FW'(1)) ? slot[c][0] : add_y[c];
        add_b[c] = slot[c][fold_i[IW-1:0]];
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_add
    fp16_add_pipe #(.LAT(ADD_LAT)) u_add (
      .clk (clk),
      .rst (rst),
      .a   (add_a[c]),
      .b   (add_b[c]),
      .y   (add_y[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        tag_v[i]   <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      tag_v[0]   <= hs;
      tag_idx[0] <= idx;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_ready_o   <= 1'b0;
      m_valid_o   <= 1'b0;
      busy_o      <= 1'b0;
      m_len_err_o <= 1'b0;
      m_sum_o     <= '0;
      n_len       <= '0;
      beat_cnt    <= '0;
      idx         <= '0;
      fold_i      <= '0;
      wait_cnt    <= '0;
      for (int c = 0; c < CH; c++)
        for (int s = 0; s < SLOTS; s++) slot[c][s] <= '0;
    end else begin
      if (tag_v[ADD_LAT-1])
        for (int c = 0; c < CH; c++) slot[c][tag_idx[ADD_LAT-1]] <= add_y[c];
      case (state)
        IDLE: begin
          if (start_i) begin
            for (int c = 0; c < CH; c++)
              for (int s = 0; s < SLOTS; s++) slot[c][s] <= '0;
            n_len       <= n_clamp;
            beat_cnt    <= '0;
            idx         <= '0;
            m_len_err_o <= 1'b0;
            busy_o      <= 1'b1;
            if (n_clamp == '0) begin
              m_sum_o   <= '0;
              m_valid_o <= 1'b1;
              state     <= OUT;
            end else begin
              s_ready_o <= 1'b1;
              state     <= ACC;
            end
          end
        end
        ACC: begin
          if (hs) begin
            if (s_last_i != (beat_cnt == n_len - NW'(1))) m_len_err_o <= 1'b1;
            idx      <= (idx == IW'(SLOTS - 1)) ? '0 : idx + IW'(1);
            beat_cnt <= beat_cnt + NW'(1);
            if (beat_cnt == n_len - NW'(1)) begin
              s_ready_o <= 1'b0;
              wait_cnt  <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wait_cnt == CW'(ADD_LAT - 1)) begin
            fold_i   <= FW'(1);
            wait_cnt <= '0;
            state    <= FOLD;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        FOLD: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end else if (fold_i == FW'(SLOTS)) begin
            for (int c = 0; c < CH; c++) m_sum_o[DW*c +: DW] <= add_y[c];
            m_valid_o <= 1'b1;
            state     <= OUT;
          end else begin
            fold_i   <= fold_i + FW'(1);
            wait_cnt <= CW'(ADD_LAT - 1);
          end
        end
        OUT: begin
          if (m_ready_i) begin
            m_valid_o   <= 1'b0;
            m_len_err_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/accum_n_stream.md
Name: accum_n_stream

Overview:
- Streaming FP16 reduction over the n dimension for CH parallel (h,p) channels. One n-sample per channel per input beat.
- The job length is set at run time. Input is ready/valid; output is valid/ready and holds until taken.
- The adder is pipelined; each channel keeps ADD_LAT+1 rotating partial sums and folds them at job end.
- Sits between the hC product stage and the y-output stage of the SSM datapath.

Parameters:
- DW, 16, sample width (FP16; fixed at 16).
- CH, 4, number of parallel (h,p) channels.
- N_MAX, 128, maximum job length in beats.
- ADD_LAT, 3, latency of the FP16 adder in cycles (≥1).
- Derived, not overridable: NW = $clog2(N_MAX+1); SLOTS = ADD_LAT+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  job start pulse; ignored unless IDLE.
- n_len_i  in  NW  job length, sampled with start_i; valid range 0..N_MAX.
- busy_o  out  1  high whenever state≠IDLE.
- s_valid_i  in  1  input beat valid.
- s_ready_o  out  1  input beat ready.
- s_data_i  in  CH*DW  one sample per channel; channel c at bits [DW*c +: DW].
- s_last_i  in  1  producer's last-beat marker, checked only.
- m_valid_o  out  1  result valid.
- m_ready_i  in  1  result accepted.
- m_sum_o  out  CH*DW  per-channel FP16 sums, same packing as s_data_i.
- m_len_err_o  out  1  s_last_i disagreed with the count; valid with m_valid_o.

Behaviour:
- Reset: state IDLE. s_ready_o, m_valid_o, busy_o, m_len_err_o = 0. m_sum_o = 0. All slots = +0.0 (0x0000).
- A reset mid-job aborts it; no output is produced.
- Arithmetic:
  - CH instances of the team's pipelined FP16 adder fp16_add_pipe, LAT=ADD_LAT, RNE.
  - All special-value and subnormal handling is the adder's; the block does no arithmetic of its own.
- States:
  - IDLE: on start_i, clear all slots to 0x0000 and latch n_len_i.
    - If n_len_i==0, go to OUT with sums 0x0000.
    - Otherwise go to ACC with beat counter = 0 and slot index = 0.
  - ACC:
    - s_ready_o=1.
    - Each handshake (s_valid_i & s_ready_o) feeds slot[idx] + s_data_i[c] into adder c. idx advances mod SLOTS and the beat counter increments.
    - Adder results are written back to the tagged slot ADD_LAT cycles later. SLOTS=ADD_LAT+1 guarantees no read-after-write hazard, so no bypass is needed.
    - s_last_i is compared with (counter==n_len-1) on each handshake; any mismatch sets the sticky err flag.
    - After the n_len-th handshake, s_ready_o drops the next cycle and the state moves to DRAIN.
    - Input gaps (s_valid_i low) stall the counter and idx only. The pipeline continues.
  - DRAIN: wait ADD_LAT cycles until all write-backs have landed, then go to FOLD.
  - FOLD:
    - Serial fold: acc = slot0; for i = 1..SLOTS-1, acc = acc + slot[i].
    - Each add waits for its result (ADD_LAT cycles). Unused slots contribute +0.0.
    - Then go to OUT.
  - OUT:
    - m_valid_o=1; m_sum_o and m_len_err_o are held stable.
    - On m_ready_i, go to IDLE the next cycle, clearing m_valid_o and err.
- Output latency: with no stall, m_valid_o rises ADD_LAT*SLOTS+1 cycles after the clock edge of the final input handshake.
- An n_len=0 job asserts m_valid_o one cycle after start_i.
- start_i outside IDLE is ignored. This includes the same cycle in which OUT completes.
- n_len_i > N_MAX is clamped to N_MAX.
- An all −0.0 input produces +0.0 (slot init is +0.0). This is accepted behaviour.

Test Plan:
- CH=2, ADD_LAT=3, n_len=4; ch0 all 0x3C00, ch1 all 0x3800; no gaps, s_last on beat 3 -> m_sum = {0x4000, 0x4400}, m_len_err_o=0, m_valid_o exactly 13 cycles after the last handshake.
- n_len=128, all 0x3C00, random s_valid_i gaps (~30%) -> m_sum each channel 0x5800, s_ready_o low after beat 128, exactly 128 beats consumed.
- n_len=0 -> m_valid_o the cycle after start_i, m_sum all 0x0000, s_ready_o never high.
- Result held: m_ready_i low 10 cycles -> m_sum_o and m_valid_o stable, busy_o=1, start_i pulses ignored. m_ready_i high -> IDLE next cycle; a new job then runs correctly.
- n_len=5 with s_last_i on beat 2 only -> m_len_err_o=1 with the result. Next job with s_last_i on beat 4 -> m_len_err_o=0.
- Alternating +1.0/−1.0 (0x3C00/0xBC00), n_len=8 -> 0x0000. Assert rst during ACC -> next cycle s_ready_o=0, busy_o=0, no m_valid_o; a following job with n_len=3 of 0x4000 returns 0x4600.
